// File: rtl/sync_link_pkg.sv
// Symbol definitions for the serial reset-code link, shared by the sync-board
// transmitter and the backend receiver.
package sync_link_pkg;

    localparam int RST_BITS   = 4;
    localparam int SYM_PERIOD = 4;

    localparam logic [RST_BITS-1:0] RST_IDLE   = 4'b1010;
    localparam logic [RST_BITS-1:0] RST_ACTIVE = 4'b1100;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } link_state_t;

endpackage

// File: rtl/rst_code_rx_pulse_stretch.sv
// Retriggerable countdown that stretches a one-cycle reset strobe into a
// RST_HOLD-cycle reset level.
module pulse_stretch #(
    parameter int RST_HOLD = 16
) (
    input  logic clk_100,
    input  logic rst_n,
    input  logic pulse,
    output logic rst_out
);

    localparam int                CNT_W = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD  = CNT_W'(RST_HOLD);

    logic [CNT_W-1:0] cnt;

    // A new pulse always reloads, so overlapping requests merge into one level.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pulse) begin
            cnt <= HOLD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign rst_out = (cnt != '0);

endmodule

// File: rtl/rst_code_rx.sv
// Backend receiver for the serial reset-code line: frame alignment, lock
// tracking, ACTIVE detection and symbol-error accounting.
module rst_code_rx
    import sync_link_pkg::*;
#(
    parameter int LOCK_COUNT  = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int RST_HOLD    = 16,
    parameter int ERR_W       = 16
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             m_rst,
    input  logic             clear_err,
    output logic             locked,
    output logic             rst_pulse,
    output logic             rst_out,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       active_count
);

    localparam int PH_W   = $clog2(SYM_PERIOD);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(UNLOCK_ERRS - 1);
    localparam logic [PH_W-1:0]   HALF_SYM  = PH_W'(SYM_PERIOD / 2);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    link_state_t         state;
    logic                din_q;
    logic [RST_BITS-1:0] win;
    logic [PH_W-1:0]     ph;
    logic [PH_W-1:0]     lock_ph;
    logic [PH_W-1:0]     alt_ph;
    logic [GOOD_W-1:0]   good;
    logic [RUN_W-1:0]    err_run;
    logic                pending;
    logic                is_idle;
    logic                is_active;
    logic                at_bnd;
    logic                at_alt;

    assign is_idle   = (win == RST_IDLE);
    assign is_active = (win == RST_ACTIVE);
    assign alt_ph    = lock_ph + HALF_SYM;
    assign at_bnd    = (ph == lock_ph);
    assign at_alt    = (ph == alt_ph);

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            din_q        <= 1'b0;
            win          <= '0;
            ph           <= '0;
            lock_ph      <= '0;
            good         <= '0;
            err_run      <= '0;
            pending      <= 1'b0;
            locked       <= 1'b0;
            rst_pulse    <= 1'b0;
            err_count    <= '0;
            active_count <= '0;
        end else begin
            din_q     <= m_rst;
            win       <= {win[RST_BITS-2:0], din_q};
            ph        <= ph + 1'b1;
            rst_pulse <= 1'b0;

            case (state)
                HUNT: begin
                    if (is_idle) begin
                        lock_ph <= ph;
                        good    <= GOOD_W'(1);
                        err_run <= '0;
                        pending <= 1'b0;
                        state   <= VERIFY;
                    end
                end

                VERIFY: begin
                    if (at_bnd) begin
                        if (!is_idle) begin
                            state <= HUNT;
                        end else if (good == GOOD_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good <= good + 1'b1;
                        end
                    end
                end

                LOCKED: begin
                    if (at_bnd) begin
                        if (is_idle) begin
                            err_run <= '0;
                        end else if (is_active) begin
                            rst_pulse    <= 1'b1;
                            active_count <= active_count + 8'd1;
                            err_run      <= '0;
                        end else begin
                            pending <= 1'b1;
                        end
                    end else if (at_alt && pending) begin
                        // IDLE also matches two bits off; an ACTIVE here means we
                        // locked on the wrong half of the symbol, so re-centre.
                        pending <= 1'b0;
                        if (is_active) begin
                            lock_ph      <= alt_ph;
                            rst_pulse    <= 1'b1;
                            active_count <= active_count + 8'd1;
                        end else begin
                            err_count <= sat_inc(err_count);
                            if (err_run == RUN_LAST) begin
                                err_run <= '0;
                                locked  <= 1'b0;
                                state   <= HUNT;
                            end else begin
                                err_run <= err_run + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase

            if (clear_err) begin
                err_count <= '0;
            end
        end
    end

    pulse_stretch #(
        .RST_HOLD(RST_HOLD)
    ) u_stretch (
        .clk_100(clk_100),
        .rst_n  (rst_n),
        .pulse  (rst_pulse),
        .rst_out(rst_out)
    );

endmodule

// File: tb/tb_rst_code_rx.sv
// Directed/randomized bench for rst_code_rx; expectations are derived from the
// symbol edges the bench drives (pulse at edge+2, stretch from edge+3, etc.).
module tb_rst_code_rx;
    import sync_link_pkg::*;

    localparam int LOCK_COUNT  = 8;
    localparam int UNLOCK_ERRS = 4;
    localparam int RST_HOLD    = 16;
    localparam int ERR_W       = 16;

    logic             clk_100 = 1'b0;
    logic             rst_n;
    logic             m_rst;
    logic             clear_err;
    logic             locked;
    logic             rst_pulse;
    logic             rst_out;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       active_count;

    rst_code_rx #(
        .LOCK_COUNT (LOCK_COUNT),
        .UNLOCK_ERRS(UNLOCK_ERRS),
        .RST_HOLD   (RST_HOLD),
        .ERR_W      (ERR_W)
    ) dut (
        .clk_100     (clk_100),
        .rst_n       (rst_n),
        .m_rst       (m_rst),
        .clear_err   (clear_err),
        .locked      (locked),
        .rst_pulse   (rst_pulse),
        .rst_out     (rst_out),
        .err_count   (err_count),
        .active_count(active_count)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge.
    int pulse_q[$];
    int rise_q[$];
    int run_start_q[$];
    int run_len_q[$];
    int run_len = 0;
    int run_start = 0;
    logic prev_locked = 1'b0;

    always @(negedge clk_100) begin
        if (rst_pulse === 1'b1) pulse_q.push_back(cyc);
        if (locked === 1'b1 && prev_locked !== 1'b1) rise_q.push_back(cyc);
        prev_locked <= locked;
        if (rst_out === 1'b1) begin
            if (run_len == 0) run_start <= cyc;
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            run_start_q.push_back(run_start);
            run_len_q.push_back(run_len);
            run_len <= 0;
        end
    end

    int total = 0;
    int passed = 0;
    int last_edge = 0;
    int exp_active = 0;
    int exp_err = 0;
    logic [3:0] bad_syms [6] = '{4'b1000, 4'b1001, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b, input logic c);
        @(negedge clk_100);
        m_rst     = b;
        clear_err = c;
        last_edge = cyc + 1;
    endtask

    task automatic send_sym(input logic [3:0] s, input logic [3:0] clr = 4'b0000);
        for (int i = 3; i >= 0; i--) send_bit(s[i], clr[i]);
    endtask

    task automatic clr_mon();
        #1;
        pulse_q.delete();
        rise_q.delete();
        run_start_q.delete();
        run_len_q.delete();
    endtask

    task automatic assert_rst();
        @(negedge clk_100);
        #2;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        m_rst     = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_pulse"}, rst_pulse, 0);
        check({tag, "_rst_out"}, rst_out, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_active"}, active_count, 0);
    endtask

    // Lock from a zero-filled line: first IDLE match plus LOCK_COUNT-1 aligned
    // IDLEs, decision visible two edges after the last bit of the 8th IDLE.
    task automatic lock_from_zero(input string tag);
        int e1;
        clr_mon();
        repeat ($urandom_range(0, 5)) send_bit(1'b0, 1'b0);
        send_sym(RST_IDLE);
        e1 = last_edge;
        repeat (11) send_sym(RST_IDLE);
        check({tag, "_rises"}, rise_q.size(), 1);
        check({tag, "_rise_cyc"}, (rise_q.size() > 0) ? rise_q[0] : -1, e1 + 4 * (LOCK_COUNT - 1) + 2);
        check({tag, "_locked"}, locked, 1);
    endtask

    initial begin
        int ea, gap, sp, s;
        rst_n     = 1'b0;
        m_rst     = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk_100);
        check_zero("reset");

        // Initial lock on a clean IDLE stream
        release_rst();
        lock_from_zero("lock1");
        check("lock1_err", err_count, 0);
        check("lock1_no_pulse", pulse_q.size(), 0);

        // Single ACTIVE
        clr_mon();
        repeat ($urandom_range(1, 4)) send_sym(RST_IDLE);
        send_sym(RST_ACTIVE);
        ea = last_edge;
        repeat (6) send_sym(RST_IDLE);
        exp_active += 1;
        check("act1_npulse", pulse_q.size(), 1);
        check("act1_pulse_cyc", (pulse_q.size() > 0) ? pulse_q[0] : -1, ea + 2);
        check("act1_nrun", run_len_q.size(), 1);
        check("act1_run_start", (run_start_q.size() > 0) ? run_start_q[0] : -1, ea + 3);
        check("act1_run_len", (run_len_q.size() > 0) ? run_len_q[0] : -1, RST_HOLD);
        check("act1_active", active_count, exp_active);

        // Two ACTIVEs: fixed 8-cycle spacing, then a random spacing
        for (int k = 0; k < 2; k++) begin
            gap = (k == 0) ? 1 : $urandom_range(0, 2);
            sp  = 4 * (gap + 1);
            clr_mon();
            send_sym(RST_ACTIVE);
            ea = last_edge;
            repeat (gap) send_sym(RST_IDLE);
            send_sym(RST_ACTIVE);
            repeat (6) send_sym(RST_IDLE);
            exp_active += 2;
            check("dbl_npulse", pulse_q.size(), 2);
            check("dbl_pulse0", (pulse_q.size() > 0) ? pulse_q[0] : -1, ea + 2);
            check("dbl_pulse1", (pulse_q.size() > 1) ? pulse_q[1] : -1, ea + 2 + sp);
            check("dbl_nrun", run_len_q.size(), 1);
            check("dbl_run_len", (run_len_q.size() > 0) ? run_len_q[0] : -1, RST_HOLD + sp);
            check("dbl_active", active_count, exp_active);
        end

        // One corrupted IDLE, then a run of UNLOCK_ERRS corrupted symbols
        send_sym(4'b1110);
        repeat (2) send_sym(RST_IDLE);
        exp_err += 1;
        check("err1_count", err_count, exp_err);
        check("err1_locked", locked, 1);
        for (int k = 0; k < UNLOCK_ERRS; k++) send_sym(bad_syms[$urandom_range(0, 5)]);
        repeat (2) send_sym(RST_IDLE);
        exp_err += UNLOCK_ERRS;
        check("unlock_count", err_count, exp_err);
        check("unlock_locked", locked, 0);

        // clear_err on its own
        send_sym(RST_IDLE, 4'b0100);
        send_sym(RST_IDLE);
        exp_err = 0;
        check("clear_alone", err_count, exp_err);

        // Reset while in VERIFY, then a full re-lock
        assert_rst();
        check_zero("rst_verify");
        release_rst();
        clr_mon();
        repeat (4) send_sym(RST_IDLE);
        assert_rst();
        check_zero("rst_verify2");
        release_rst();
        lock_from_zero("relock");
        exp_active = 0;

        // clear_err in the same cycle an error commits: the clear wins
        send_sym(4'b1110);
        send_sym(RST_IDLE, 4'b0001);
        send_sym(RST_IDLE);
        check("clear_vs_err", err_count, 0);
        check("clear_vs_err_locked", locked, 1);
        send_sym(4'b1011);
        repeat (2) send_sym(RST_IDLE);
        check("err_after_clear", err_count, 1);

        // Reset while rst_out is held
        send_sym(RST_ACTIVE);
        send_sym(RST_IDLE);
        check("hold_pre_rst", rst_out, 1);
        assert_rst();
        check_zero("rst_hold");
        release_rst();

        // Lock two bits off the symbol grid, then resolve it with an ACTIVE
        clr_mon();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (12) send_sym(RST_IDLE);
        check("wph_locked", locked, 1);
        clr_mon();
        send_sym(RST_ACTIVE);
        ea = last_edge;
        repeat (4) send_sym(RST_IDLE);
        check("wph_npulse", pulse_q.size(), 1);
        check("wph_pulse_cyc", (pulse_q.size() > 0) ? pulse_q[0] : -1, ea + 2);
        check("wph_err", err_count, 0);
        check("wph_active", active_count, 1);
        check("wph_locked2", locked, 1);

        // Line stuck while locked: lock drops after UNLOCK_ERRS errors
        clr_mon();
        s = $urandom_range(0, 1);
        repeat (28) send_bit(s[0], 1'b0);
        check("stuck_lock_drop", locked, 0);
        check("stuck_lock_err", err_count, UNLOCK_ERRS);
        check("stuck_lock_nopulse", pulse_q.size(), 0);

        // Line stuck from reset: never locks
        assert_rst();
        release_rst();
        clr_mon();
        s = $urandom_range(0, 1);
        repeat (40) send_bit(s[0], 1'b0);
        check("stuck_hunt_locked", locked, 0);
        check("stuck_hunt_rises", rise_q.size(), 0);
        check("stuck_hunt_nopulse", pulse_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
